// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Purpose : Definitions shared by the single-cycle MIPS datapath blocks:
//           default widths, architectural register indices and the ALU
//           control encoding used by both the decoder and the ALU.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_SLT = 3'b100
    } alu_ctrl_e;

endpackage

`default_nettype wire

// File: rtl/wb_mux.sv
// ============================================================================
// Module  : wb_mux
// Purpose : Write-back selection. Chooses the destination register index
//           (rd for R-type, rt for I-type) and the write data (memory load
//           data or ALU result). Purely combinational.
// Ports   : reg_dst, memtoreg       - decoder selects
//           rt_addr, rd_addr        - candidate destination indices
//           alu_result, mem_rdata   - candidate write data
//           waddr, wdata            - selected destination and data
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              reg_dst,
    input  logic              memtoreg,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    assign waddr = reg_dst  ? rd_addr   : rt_addr;
    assign wdata = memtoreg ? mem_rdata : alu_result;

endmodule

`default_nettype wire

// File: rtl/reg_file_wb.sv
// ============================================================================
// Module  : reg_file_wb
// Purpose : Register file plus write-back stage of the single-cycle MIPS
//           datapath. Two combinational operand read ports, one debug read
//           port, one write port committed on the rising clock edge, and a
//           saturating count of committed writes.
// Ports   : clk, rst (async, active high), hold (freeze commits)
//           rs_addr, rt_addr, rd_addr  - instruction register fields
//           reg_write, reg_dst, memtoreg - decoder controls
//           alu_result, mem_rdata      - write-back data sources
//           rs_data, rt_data           - operand reads
//           dbg_addr / dbg_data        - debug read port
//           wr_count                   - committed-write counter
//           trace_valid/addr/data      - commit trace (RF_WR_TRACE_EN only)
// Config  : define RF_WR_TRACE_EN to add the registered commit-trace outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_wb
    import mips_pkg::*;
#(
    parameter int                DATA_W   = MIPS_DATA_W,
    parameter int                ADDR_W   = MIPS_ADDR_W,
    parameter logic [DATA_W-1:0] SP_RESET = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              reg_write,
    input  logic              reg_dst,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
`ifdef RF_WR_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data
`endif
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam int                SP_IDX   = int'(REG_SP);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we_eff;

    wb_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_mux (
        .reg_dst    (reg_dst),
        .memtoreg   (memtoreg),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    // Writes to $0 are dropped here, so they neither change state nor count.
    assign we_eff = reg_write & ~hold & (waddr != ZERO_IDX);

    // Entry 0 is reset to zero and never written; the read ports also force
    // index 0 to zero so $0 is hardwired regardless of array contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (we_eff) begin
            regs[waddr] <= wdata;
        end
    end

    // Saturating commit counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if (we_eff && (wr_count != {CNT_W{1'b1}})) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // Reads come straight from the array with no bypass: a same-cycle read
    // of the destination sees the old value. Forwarding wdata here would
    // form a combinational loop through the ALU in the single-cycle path.
    assign rs_data  = (rs_addr  == ZERO_IDX) ? '0 : regs[rs_addr];
    assign rt_data  = (rt_addr  == ZERO_IDX) ? '0 : regs[rt_addr];
    assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : regs[dbg_addr];

`ifdef RF_WR_TRACE_EN
    // One-cycle record of the commit performed on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= we_eff;
            if (we_eff) begin
                trace_addr <= waddr;
                trace_data <= wdata;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_file_wb.sv
// ============================================================================
// Module  : tb_reg_file_wb
// Purpose : Self-checking bench for reg_file_wb. A behavioural register-file
//           model tracks the expected contents; a compare process checks all
//           read ports and counters every cycle, and directed sequences pin
//           literal values (reset, R-type, lw, sw, $0, read-during-write,
//           hold, counter saturation on a 4-bit counter instance).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_wb;

    localparam logic [31:0] SP = 32'h0000_3FFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0, dbg_addr = '0;
    logic        reg_write = 1'b0, reg_dst = 1'b0, memtoreg = 1'b0;
    logic [31:0] alu_result = '0, mem_rdata = '0;
    logic [31:0] rs_data, rt_data, dbg_data;
    logic [31:0] rs_data4, rt_data4, dbg_data4;
    logic [31:0] wr_count;
    logic [3:0]  wr_count4;
`ifdef RF_WR_TRACE_EN
    logic        trace_valid, trace_valid4;
    logic [4:0]  trace_addr, trace_addr4;
    logic [31:0] trace_data, trace_data4;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .SP_RESET(SP), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .reg_dst(reg_dst), .memtoreg(memtoreg),
        .alu_result(alu_result), .mem_rdata(mem_rdata),
        .rs_data(rs_data), .rt_data(rt_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .wr_count(wr_count)
`ifdef RF_WR_TRACE_EN
        , .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data)
`endif
    );

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .SP_RESET(SP), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hold(hold),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .reg_dst(reg_dst), .memtoreg(memtoreg),
        .alu_result(alu_result), .mem_rdata(mem_rdata),
        .rs_data(rs_data4), .rt_data(rt_data4),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data4),
        .wr_count(wr_count4)
`ifdef RF_WR_TRACE_EN
        , .trace_valid(trace_valid4), .trace_addr(trace_addr4), .trace_data(trace_data4)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    longint      m_cnt;
    bit          m_tv;
    logic [4:0]  m_ta;
    logic [31:0] m_td;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_regs[29] = SP;
            m_cnt = 0;
            m_tv = 0; m_ta = '0; m_td = '0;
        end else begin
            automatic logic [4:0]  a = reg_dst ? rd_addr : rt_addr;
            automatic logic [31:0] d = memtoreg ? mem_rdata : alu_result;
            automatic bit commit = (reg_write === 1'b1) && !hold && (a != 0);
            m_tv = commit;
            if (commit) begin
                m_regs[a] = d;
                m_cnt++;
                m_ta = a; m_td = d;
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (a == 0) ? 32'h0 : m_regs[a];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("rs_data",   rs_data,   m_read(rs_addr));
            chk("rt_data",   rt_data,   m_read(rt_addr));
            chk("dbg_data",  dbg_data,  m_read(dbg_addr));
            chk("rs_data4",  rs_data4,  m_read(rs_addr));
            chk("wr_count",  wr_count,  m_cnt[31:0]);
            chk("wr_count4", wr_count4, (m_cnt > 15) ? 64'd15 : m_cnt);
`ifdef RF_WR_TRACE_EN
            chk("trace_valid", trace_valid, m_tv);
            if (m_tv) begin
                chk("trace_addr", trace_addr, m_ta);
                chk("trace_data", trace_data, m_td);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic dst, input logic mtr, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem);
        reg_write = 1'b1; reg_dst = dst; memtoreg = mtr;
        rt_addr = rt; rd_addr = rd; alu_result = alu; mem_rdata = mem;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #12 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        rs_addr = 5'd29; rt_addr = 5'd5; dbg_addr = 5'd0;
        #1;
        chk("reset_sp",    rs_data, SP);
        chk("reset_r5",    rt_data, 32'h0);
        chk("reset_cnt",   wr_count, 32'h0);

        // R-type add into rd=8
        @(posedge clk); #1;
        wr(1'b1, 1'b0, 5'd9, 5'd8, 32'h0000_0055, 32'hCAFE_0000);
        tick();
        reg_write = 1'b0; rs_addr = 5'd8; rt_addr = 5'd9;
        #1;
        chk("rtype_r8",  rs_data, 32'h55);
        chk("rtype_r9",  rt_data, 32'h0);
        chk("rtype_cnt", wr_count, 32'd1);
`ifdef RF_WR_TRACE_EN
        chk("trace_pulse", trace_valid, 1'b1);
        chk("trace_a8",    trace_addr, 5'd8);
        chk("trace_d55",   trace_data, 32'h55);
`endif
        tick();
`ifdef RF_WR_TRACE_EN
        chk("trace_drop", trace_valid, 1'b0);
`endif

        // lw into rt=10
        wr(1'b0, 1'b1, 5'd10, 5'd3, 32'hFFFF_FFFF, 32'h1234_5678);
        tick();
        reg_write = 1'b0; dbg_addr = 5'd10;
        #1;
        chk("lw_r10", dbg_data, 32'h1234_5678);
        chk("lw_cnt", wr_count, 32'd2);

        // sw: memtoreg=1 without reg_write
        reg_write = 1'b0; memtoreg = 1'b1; rt_addr = 5'd10; mem_rdata = 32'hAAAA_AAAA;
        tick();
        chk("sw_r10", dbg_data, 32'h1234_5678);
        chk("sw_cnt", wr_count, 32'd2);

        // write to $0 dropped
        wr(1'b1, 1'b0, 5'd4, 5'd0, 32'd7, 32'd0);
        tick();
        reg_write = 1'b0; dbg_addr = 5'd0;
        #1;
        chk("r0_data", dbg_data, 32'h0);
        chk("r0_cnt",  wr_count, 32'd2);

        // read during write
        wr(1'b1, 1'b0, 5'd3, 5'd3, 32'd1, 32'd0);
        tick();
        wr(1'b1, 1'b0, 5'd3, 5'd3, 32'd2, 32'd0);
        rs_addr = 5'd3;
        #1;
        chk("rdw_rs_old", rs_data, 32'd1);
        chk("rdw_rt_old", rt_data, 32'd1);
        tick();
        reg_write = 1'b0;
        #1;
        chk("rdw_rs_new", rs_data, 32'd2);
        chk("rdw_rt_new", rt_data, 32'd2);
        chk("rdw_cnt",    wr_count, 32'd4);

        // hold freezes commit
        hold = 1'b1;
        wr(1'b1, 1'b0, 5'd3, 5'd3, 32'd99, 32'd0);
        tick();
        reg_write = 1'b0;
        #1;
        chk("hold_r3",  rs_data, 32'd2);
        chk("hold_cnt", wr_count, 32'd4);
        hold = 1'b0;

        // randomized traffic, checked by the compare process
        for (int n = 0; n < 1500; n++) begin
            reg_write  = ($urandom_range(0, 9) < 7);
            hold       = ($urandom_range(0, 9) < 2);
            reg_dst    = $urandom_range(0, 1);
            memtoreg   = $urandom_range(0, 1);
            rs_addr    = 5'($urandom_range(0, 31));
            rt_addr    = 5'($urandom_range(0, 31));
            rd_addr    = 5'($urandom_range(0, 31));
            dbg_addr   = 5'($urandom_range(0, 31));
            alu_result = $urandom;
            mem_rdata  = $urandom;
            tick();
        end
        hold = 1'b0;

        // asynchronous reset in mid-cycle
        wr(1'b1, 1'b0, 5'd4, 5'd5, 32'hDEAD_BEEF, 32'd0);
        tick();
        reg_write = 1'b0; rs_addr = 5'd5; rt_addr = 5'd29;
        #1;
        chk("pre_rst_r5", rs_data, 32'hDEAD_BEEF);
        #1 rst = 1'b1;
        #1;
        chk("async_r5",   rs_data, 32'h0);
        chk("async_sp",   rt_data, SP);
        chk("async_cnt",  wr_count, 32'h0);
        chk("async_cnt4", wr_count4, 4'h0);
        wr(1'b1, 1'b0, 5'd4, 5'd5, 32'h1, 32'd0);
        @(posedge clk); #2;
        chk("rst_discard", rs_data, 32'h0);
        reg_write = 1'b0;
        rst = 1'b0;

        // 20 commits: 32-bit counter reaches 20, 4-bit one sticks at F
        for (int k = 1; k <= 20; k++) begin
            wr(1'b1, 1'b0, 5'd0, 5'(k), 32'(k * 3), 32'd0);
            tick();
        end
        reg_write = 1'b0; rs_addr = 5'd20;
        #1;
        chk("sat_cnt32", wr_count, 32'd20);
        chk("sat_cnt4",  wr_count4, 4'hF);
        chk("sat_r20",   rs_data, 32'd60);
        tick();
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
